// File: rtl/batchnorm_stats_accumulator.sv
// Running mean/variance over 2**LOG2_N signed Q.FRAC samples of one channel.
// One-shot per start; results are held until the next run completes.
module batchnorm_stats_accumulator #(
    parameter int WIDTH  = 16,
    parameter int FRAC   = 8,
    parameter int LOG2_N = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             x_valid,
    input  logic [WIDTH-1:0] x_in,
    output logic             x_ready,
    output logic             busy,
    output logic [WIDTH-1:0] mean_out,
    output logic [WIDTH-1:0] variance_out,
    output logic             stats_valid
);

    localparam int SUM_W  = WIDTH + LOG2_N;
    localparam int SQ_W   = 2 * WIDTH + LOG2_N;
    localparam int PROD_W = 2 * WIDTH;
    localparam int V_W    = 2 * WIDTH + 2;

    localparam logic [LOG2_N-1:0]    LAST_IDX = '1;
    localparam logic signed [V_W-1:0] V_MAX   = V_W'({(WIDTH-1){1'b1}});

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_CALC1,
        S_CALC2,
        S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic signed [SUM_W-1:0]    sum_q, sum_d;
    logic [SQ_W-1:0]            sumsq_q, sumsq_d;
    logic [LOG2_N-1:0]          count_q, count_d;
    logic signed [WIDTH-1:0]    mean_r_q, mean_r_d;
    logic [PROD_W-1:0]          ex2_r_q, ex2_r_d;
    logic                       x_ready_q, x_ready_d;
    logic                       busy_q, busy_d;
    logic                       stats_valid_q, stats_valid_d;
    logic [WIDTH-1:0]           mean_out_q, mean_out_d;
    logic [WIDTH-1:0]           variance_out_q, variance_out_d;

    logic signed [WIDTH-1:0]    x_s;
    logic signed [PROD_W-1:0]   x_sq;
    logic signed [PROD_W-1:0]   mean_sq;
    logic signed [PROD_W-1:0]   msq;
    logic signed [V_W-1:0]      v;
    logic [WIDTH-1:0]           v_sat;

    // Square terms are never negative, so zero-extending them into sumsq is exact.
    always_comb begin
        x_s     = x_in;
        x_sq    = x_s * x_s;
        mean_sq = mean_r_q * mean_r_q;
        msq     = mean_sq >>> FRAC;
        v       = $signed(V_W'(ex2_r_q)) - V_W'(msq);
        if (v < 0) begin
            v_sat = '0;
        end else if (v > V_MAX) begin
            v_sat = WIDTH'(V_MAX);
        end else begin
            v_sat = WIDTH'(v);
        end
    end

    always_comb begin
        state_d        = state_q;
        sum_d          = sum_q;
        sumsq_d        = sumsq_q;
        count_d        = count_q;
        mean_r_d       = mean_r_q;
        ex2_r_d        = ex2_r_q;
        x_ready_d      = x_ready_q;
        busy_d         = busy_q;
        stats_valid_d  = 1'b0;
        mean_out_d     = mean_out_q;
        variance_out_d = variance_out_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_ACCUM;
                    sum_d     = '0;
                    sumsq_d   = '0;
                    count_d   = '0;
                    x_ready_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            S_ACCUM: begin
                if (x_valid && x_ready_q) begin
                    sum_d   = sum_q + SUM_W'(x_s);
                    sumsq_d = sumsq_q + SQ_W'($unsigned(x_sq));
                    count_d = count_q + LOG2_N'(1);
                    if (count_q == LAST_IDX) begin
                        state_d   = S_CALC1;
                        x_ready_d = 1'b0;
                    end
                end
            end
            S_CALC1: begin
                mean_r_d = WIDTH'(sum_q >>> LOG2_N);
                ex2_r_d  = PROD_W'(sumsq_q >> (LOG2_N + FRAC));
                state_d  = S_CALC2;
            end
            S_CALC2: begin
                mean_out_d     = mean_r_q;
                variance_out_d = v_sat;
                stats_valid_d  = 1'b1;
                state_d        = S_DONE;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            sum_q          <= '0;
            sumsq_q        <= '0;
            count_q        <= '0;
            mean_r_q       <= '0;
            ex2_r_q        <= '0;
            x_ready_q      <= 1'b0;
            busy_q         <= 1'b0;
            stats_valid_q  <= 1'b0;
            mean_out_q     <= '0;
            variance_out_q <= '0;
        end else begin
            state_q        <= state_d;
            sum_q          <= sum_d;
            sumsq_q        <= sumsq_d;
            count_q        <= count_d;
            mean_r_q       <= mean_r_d;
            ex2_r_q        <= ex2_r_d;
            x_ready_q      <= x_ready_d;
            busy_q         <= busy_d;
            stats_valid_q  <= stats_valid_d;
            mean_out_q     <= mean_out_d;
            variance_out_q <= variance_out_d;
        end
    end

    assign x_ready      = x_ready_q;
    assign busy         = busy_q;
    assign stats_valid  = stats_valid_q;
    assign mean_out     = mean_out_q;
    assign variance_out = variance_out_q;

endmodule

// File: tb/tb_batchnorm_stats_accumulator.sv
// Bench for batchnorm_stats_accumulator: N=4 and N=64 instances against an arithmetic model.
module tb_batchnorm_stats_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start4, xv4, rdy4, busy4, sv4;
    logic [15:0] x4, mean4, var4;
    logic        start64, xv64, rdy64, busy64, sv64;
    logic [15:0] x64, mean64, var64;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] samp[$];
    logic [15:0] prev_m[2];
    logic [15:0] prev_v[2];

    always #5 clk = ~clk;

    batchnorm_stats_accumulator #(.WIDTH(16), .FRAC(8), .LOG2_N(2)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .x_valid(xv4), .x_in(x4),
        .x_ready(rdy4), .busy(busy4), .mean_out(mean4), .variance_out(var4),
        .stats_valid(sv4)
    );

    batchnorm_stats_accumulator #(.WIDTH(16), .FRAC(8), .LOG2_N(6)) dut64 (
        .clk(clk), .rst(rst), .start(start64), .x_valid(xv64), .x_in(x64),
        .x_ready(rdy64), .busy(busy64), .mean_out(mean64), .variance_out(var64),
        .stats_valid(sv64)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic xv, input logic [15:0] x);
        if (sel == 0) begin
            start4 = st; xv4 = xv; x4 = x;
        end else begin
            start64 = st; xv64 = xv; x64 = x;
        end
    endtask

    function automatic logic o_rdy(input int sel);
        return (sel == 0) ? rdy4 : rdy64;
    endfunction
    function automatic logic o_busy(input int sel);
        return (sel == 0) ? busy4 : busy64;
    endfunction
    function automatic logic o_sv(input int sel);
        return (sel == 0) ? sv4 : sv64;
    endfunction
    function automatic logic [15:0] o_mean(input int sel);
        return (sel == 0) ? mean4 : mean64;
    endfunction
    function automatic logic [15:0] o_var(input int sel);
        return (sel == 0) ? var4 : var64;
    endfunction

    // Mean = floor(sum/N); variance = floor(sum(x^2)/(N*256)) - floor(mean^2/256), clamped.
    task automatic model(input int n, output logic [15:0] m, output logic [15:0] v);
        longint s = 0;
        longint sq = 0;
        longint mean, ex2, msq, var_l;
        for (int i = 0; i < n; i++) begin
            longint xs;
            xs = longint'($signed(samp[i]));
            s  += xs;
            sq += xs * xs;
        end
        mean = s / n;
        if ((s % n) != 0 && s < 0) mean -= 1;
        ex2   = sq / (n * 256);
        msq   = (mean * mean) / 256;
        var_l = ex2 - msq;
        if (var_l < 0) var_l = 0;
        if (var_l > 32767) var_l = 32767;
        m = mean[15:0];
        v = var_l[15:0];
    endtask

    task automatic run(input int sel, input string name, input bit noisy);
        int          n;
        int          idx = 0;
        int          cyc = 0;
        int          pulses = 0;
        logic        acc;
        logic [15:0] em, ev;
        n = (sel == 0) ? 4 : 64;
        model(n, em, ev);
        @(negedge clk);
        check({name, " idle x_ready"}, 32'(o_rdy(sel)), 0);
        check({name, " idle busy"}, 32'(o_busy(sel)), 0);
        drive(sel, 1'b1, noisy ? 1'($urandom_range(0, 1)) : 1'b0, 16'($urandom));
        @(negedge clk);
        check({name, " start busy"}, 32'(o_busy(sel)), 1);
        check({name, " start x_ready"}, 32'(o_rdy(sel)), 1);
        while (idx < n && cyc < n * 8 + 40) begin
            logic xv;
            xv = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (o_sv(sel)) pulses++;
            check({name, " accum x_ready"}, 32'(o_rdy(sel)), 1);
            acc = xv && o_rdy(sel);
            drive(sel, noisy ? 1'($urandom_range(0, 1)) : 1'b0, xv,
                  xv ? samp[idx] : 16'($urandom));
            @(negedge clk);
            if (acc) idx++;
            cyc++;
        end
        check({name, " accepted samples"}, 32'(idx), 32'(n));
        for (int k = 1; k <= 4; k++) begin
            if (o_sv(sel)) pulses++;
            check({name, " post x_ready"}, 32'(o_rdy(sel)), 0);
            check({name, " post stats_valid"}, 32'(o_sv(sel)), (k == 3) ? 1 : 0);
            check({name, " post busy"}, 32'(o_busy(sel)), (k <= 3) ? 1 : 0);
            if (k < 3) begin
                check({name, " mean held"}, 32'(o_mean(sel)), 32'(prev_m[sel]));
                check({name, " var held"}, 32'(o_var(sel)), 32'(prev_v[sel]));
            end else begin
                check({name, " mean_out"}, 32'(o_mean(sel)), 32'(em));
                check({name, " variance_out"}, 32'(o_var(sel)), 32'(ev));
            end
            drive(sel, (noisy && k <= 3) ? 1'($urandom_range(0, 1)) : 1'b0,
                  noisy ? 1'($urandom_range(0, 1)) : 1'b0, 16'($urandom));
            @(negedge clk);
        end
        check({name, " stats_valid pulses"}, 32'(pulses), 1);
        prev_m[sel] = em;
        prev_v[sel] = ev;
    endtask

    task automatic load4(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
        samp = {a, b, c, d};
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0);
        drive(1, 1'b0, 1'b0, 16'h0);
        prev_m = '{16'h0, 16'h0};
        prev_v = '{16'h0, 16'h0};
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("reset x_ready", 32'(o_rdy(s)), 0);
            check("reset busy", 32'(o_busy(s)), 0);
            check("reset stats_valid", 32'(o_sv(s)), 0);
            check("reset mean_out", 32'(o_mean(s)), 0);
            check("reset variance_out", 32'(o_var(s)), 0);
        end
        rst = 1'b0;

        load4(16'h0100, 16'h0100, 16'h0100, 16'h0100); run(0, "constant", 1'b0);
        load4(16'h0100, 16'h0300, 16'h0100, 16'h0300); run(0, "spread", 1'b0);
        load4(16'hFF00, 16'h0100, 16'hFF00, 16'h0100); run(0, "signed", 1'b0);
        load4(16'hFFFF, 16'h0000, 16'h0000, 16'h0000); run(0, "floor", 1'b0);
        load4(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000); run(0, "saturate", 1'b0);
        load4(16'h0100, 16'h0300, 16'h0100, 16'h0300); run(0, "handshake", 1'b1);

        // Abort a run after two accepted samples.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 16'h0);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 16'h0100);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 16'h0300);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 16'h0);
        rst = 1'b1;
        #1;
        check("abort mean_out", 32'(mean4), 0);
        check("abort variance_out", 32'(var4), 0);
        check("abort busy", 32'(busy4), 0);
        check("abort x_ready", 32'(rdy4), 0);
        @(negedge clk);
        rst = 1'b0;
        prev_m = '{16'h0, 16'h0};
        prev_v = '{16'h0, 16'h0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort no stats_valid", 32'(sv4), 0);
            check("abort idle busy", 32'(busy4), 0);
        end
        load4(16'h0100, 16'h0300, 16'h0100, 16'h0300); run(0, "after abort", 1'b0);

        for (int r = 0; r < 3; r++) begin
            samp = {};
            for (int i = 0; i < 4; i++)
                samp.push_back((r == 0) ? 16'($urandom) : 16'(16'($urandom_range(0, 2047)) - 16'd1024));
            run(0, "random4", 1'b1);
        end

        samp = {};
        for (int i = 0; i < 32; i++) begin
            samp.push_back(16'h0100);
            samp.push_back(16'h0300);
        end
        run(1, "spread64", 1'b0);
        samp = {};
        for (int i = 0; i < 64; i++) samp.push_back(16'(16'($urandom_range(0, 4095)) - 16'd2048));
        run(1, "random64", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
